// File: rtl/icache_fetcher.sv
// Instruction fetch stage with a direct-mapped cache: hits answer one cycle after FETCH,
// misses hold a valid/ready program-memory read until ready, then fill the line.
module icache_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int CACHE_LINES           = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [3:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count
);

  localparam int IDX = $clog2(CACHE_LINES);
  localparam int TAG = PROGRAM_MEM_ADDR_BITS - IDX;

  localparam logic [3:0] CORE_FETCH  = 4'b0001;
  localparam logic [3:0] CORE_DECODE = 4'b0010;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    REQUEST = 3'b010,
    FETCHED = 3'b011
  } fetch_state_t;

  fetch_state_t state_q, state_d;

  logic [CACHE_LINES-1:0]           valid_q;
  logic [TAG-1:0]                   tag_q  [CACHE_LINES];
  logic [PROGRAM_MEM_DATA_BITS-1:0] data_q [CACHE_LINES];

  logic [IDX-1:0] lk_idx, fill_idx;
  logic [TAG-1:0] lk_tag, fill_tag;
  logic           lk_hit;
  logic           do_hit, do_miss, do_fill;

  assign lk_idx = current_pc[IDX-1:0];
  assign lk_tag = current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  // The fill targets the latched request address, not whatever current_pc shows now.
  assign fill_idx = mem_read_address[IDX-1:0];
  assign fill_tag = mem_read_address[PROGRAM_MEM_ADDR_BITS-1:IDX];

  assign fetcher_state = state_q;

  always_comb begin
    state_d = state_q;
    do_hit  = 1'b0;
    do_miss = 1'b0;
    do_fill = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (lk_hit) begin
            do_hit  = 1'b1;
            state_d = FETCHED;
          end else begin
            do_miss = 1'b1;
            state_d = REQUEST;
          end
        end
      end
      REQUEST: begin
        if (mem_read_ready) begin
          do_fill = 1'b1;
          state_d = FETCHED;
        end
      end
      FETCHED: begin
        if (core_state == CORE_DECODE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      hit_count        <= '0;
      miss_count       <= '0;
      valid_q          <= '0;
    end else begin
      state_q <= state_d;
      if (do_hit) begin
        instruction <= data_q[lk_idx];
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end
      if (do_miss) begin
        mem_read_valid   <= 1'b1;
        mem_read_address <= current_pc;
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
      if (do_fill) begin
        mem_read_valid <= 1'b0;
        instruction    <= mem_read_data;
      end
      // Flush beats a same-cycle fill; the lookup above already saw the old valid bits.
      if (flush)        valid_q           <= '0;
      else if (do_fill) valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_fill && !reset) begin
      data_q[fill_idx] <= mem_read_data;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_fetcher.sv
// Directed bench for icache_fetcher: miss/hit/conflict/flush/reset/saturation.
module tb_icache_fetcher;

  localparam logic [3:0] FETCH  = 4'b0001;
  localparam logic [3:0] DECODE = 4'b0010;
  localparam logic [3:0] OTHER  = 4'b0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  core_state;
  logic [7:0]  current_pc;
  logic        flush;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_hits = 16'd0;
  logic [15:0] exp_miss = 16'd0;

  always #5 clk = ~clk;

  icache_fetcher #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16),
    .CACHE_LINES(8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .flush            (flush),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Miss with memory answering on the first REQUEST cycle, then back to IDLE via DECODE.
  task automatic fetch_miss(input string tag, input logic [7:0] pc, input logic [15:0] data);
    core_state = FETCH;
    current_pc = pc;
    step(1);
    exp_miss = sat_inc(exp_miss);
    check({tag, "_req_state"}, {29'd0, fetcher_state}, 32'h2);
    check({tag, "_req_valid"}, {31'd0, mem_read_valid}, 32'h1);
    check({tag, "_req_addr"}, {24'd0, mem_read_address}, {24'd0, pc});
    check({tag, "_miss_cnt"}, {16'd0, miss_count}, {16'd0, exp_miss});
    mem_read_ready = 1'b1;
    mem_read_data  = data;
    step(1);
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0;
    check({tag, "_fill_instr"}, {16'd0, instruction}, {16'd0, data});
    check({tag, "_fill_valid"}, {31'd0, mem_read_valid}, 32'h0);
    core_state = DECODE;
    step(1);
    check({tag, "_idle"}, {29'd0, fetcher_state}, 32'h0);
  endtask

  task automatic fetch_hit(input string tag, input logic [7:0] pc, input logic [15:0] data);
    core_state = FETCH;
    current_pc = pc;
    step(1);
    exp_hits = sat_inc(exp_hits);
    check({tag, "_hit_state"}, {29'd0, fetcher_state}, 32'h3);
    check({tag, "_hit_novalid"}, {31'd0, mem_read_valid}, 32'h0);
    check({tag, "_hit_instr"}, {16'd0, instruction}, {16'd0, data});
    check({tag, "_hit_cnt"}, {16'd0, hit_count}, {16'd0, exp_hits});
    core_state = DECODE;
    step(1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    core_state     = OTHER;
    current_pc     = 8'h00;
    flush          = 1'b0;
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0;
    step(2);
    check("rst_state", {29'd0, fetcher_state}, 32'h0);
    check("rst_valid", {31'd0, mem_read_valid}, 32'h0);
    check("rst_addr", {24'd0, mem_read_address}, 32'h0);
    check("rst_instr", {16'd0, instruction}, 32'h0);
    check("rst_hits", {16'd0, hit_count}, 32'h0);
    check("rst_miss", {16'd0, miss_count}, 32'h0);
    reset = 1'b0;
    step(1);
    check("idle_other", {29'd0, fetcher_state}, 32'h0);

    // Cold miss with memory answering after three valid cycles.
    core_state = FETCH;
    current_pc = 8'h00;
    for (int c = 1; c <= 3; c++) begin
      step(1);
      check($sformatf("cold_valid_c%0d", c), {31'd0, mem_read_valid}, 32'h1);
      check($sformatf("cold_addr_c%0d", c), {24'd0, mem_read_address}, 32'h0);
      check($sformatf("cold_state_c%0d", c), {29'd0, fetcher_state}, 32'h2);
    end
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h5123;
    step(1);
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0;
    exp_miss = 16'd1;
    check("cold_instr", {16'd0, instruction}, 32'h5123);
    check("cold_state", {29'd0, fetcher_state}, 32'h3);
    check("cold_valid_drop", {31'd0, mem_read_valid}, 32'h0);
    check("cold_miss", {16'd0, miss_count}, 32'h1);
    step(1);
    check("stuck_fetch_state", {29'd0, fetcher_state}, 32'h3);
    check("stuck_fetch_miss", {16'd0, miss_count}, 32'h1);
    check("stuck_fetch_hits", {16'd0, hit_count}, 32'h0);
    core_state = DECODE;
    step(1);
    check("decode_idle", {29'd0, fetcher_state}, 32'h0);

    fetch_hit("hit00", 8'h00, 16'h5123);

    // Conflict: pc 08 shares line 0 with pc 00.
    fetch_miss("conf08", 8'h08, 16'hA0FF);
    fetch_miss("conf00", 8'h00, 16'h5123);
    check("conf_miss3", {16'd0, miss_count}, 32'h3);

    // Flush invalidates a filled line.
    fetch_miss("fill03", 8'h03, 16'h1234);
    fetch_hit("hit03", 8'h03, 16'h1234);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    fetch_miss("postflush03", 8'h03, 16'h2222);

    // Flush coincident with the fill cycle leaves the line invalid.
    core_state = FETCH;
    current_pc = 8'h03;
    flush      = 1'b1;
    step(1);
    flush = 1'b0;
    exp_hits = sat_inc(exp_hits);
    check("flushhit_state", {29'd0, fetcher_state}, 32'h3);
    check("flushhit_instr", {16'd0, instruction}, 32'h2222);
    check("flushhit_cnt", {16'd0, hit_count}, {16'd0, exp_hits});
    core_state = DECODE;
    step(1);
    core_state = FETCH;
    step(1);
    exp_miss = sat_inc(exp_miss);
    check("flushfill_req", {29'd0, fetcher_state}, 32'h2);
    flush          = 1'b1;
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h7777;
    step(1);
    flush          = 1'b0;
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0;
    check("flushfill_instr", {16'd0, instruction}, 32'h7777);
    core_state = DECODE;
    step(1);
    fetch_miss("afterflushfill03", 8'h03, 16'h4444);
    fetch_hit("rehit03", 8'h03, 16'h4444);

    // Stray ready in IDLE is ignored.
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hBEEF;
    step(1);
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0;
    check("stray_ready_instr", {16'd0, instruction}, 32'h4444);
    check("stray_ready_state", {29'd0, fetcher_state}, 32'h0);

    // Reset mid-REQUEST, followed by a late ready.
    core_state = FETCH;
    current_pc = 8'h05;
    step(1);
    check("midreq_valid", {31'd0, mem_read_valid}, 32'h1);
    reset      = 1'b1;
    core_state = DECODE;
    step(1);
    reset = 1'b0;
    exp_hits = 16'd0;
    exp_miss = 16'd0;
    check("midreq_rst_valid", {31'd0, mem_read_valid}, 32'h0);
    check("midreq_rst_state", {29'd0, fetcher_state}, 32'h0);
    check("midreq_rst_miss", {16'd0, miss_count}, 32'h0);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hDEAD;
    step(1);
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0;
    check("late_ready_instr", {16'd0, instruction}, 32'h0);
    check("late_ready_state", {29'd0, fetcher_state}, 32'h0);
    fetch_miss("postrst00", 8'h00, 16'h5123);

    // Hit counter saturation.
    force dut.hit_count = 16'hFFFE;
    step(1);
    release dut.hit_count;
    exp_hits = 16'hFFFE;
    for (int i = 0; i < 3; i++) fetch_hit($sformatf("sat%0d", i), 8'h00, 16'h5123);
    check("sat_final", {16'd0, hit_count}, 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
